bcd_addsub_serial: RTL and testbench

- Parametrised multi-digit BCD adder/subtractor; digit-serial, one decimal digit per clock, with a start/busy/done handshake.
- Successor to the single-digit combinational BCD adder; used wherever N-digit decimal values (counters, display accumulators) need add or subtract at low area.
- Subtraction uses nines-complement plus carry.

---
 rtl/bcd_addsub_serial.sv | 172 +++++++++++++++++
 tb/tb_bcd_addsub_serial.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bcd_addsub_serial.sv
// Digit-serial N-digit BCD adder/subtractor, one decimal digit per clock with start/busy/done handshake.
// Optional invalid-digit detection is built when BCD_ADDSUB_CHECK_EN is defined; otherwise err is tied low.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   res,
  output logic                  cout,
  output logic                  err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [DIGITS-1:0][3:0]     a_q, a_d;
  logic [DIGITS-1:0][3:0]     bop_q, bop_d;
  logic [DIGITS-1:0][3:0]     wres_q, wres_d;
  logic [DIGITS-1:0][3:0]     res_q, res_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic                       c_q, c_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       cout_q, cout_d;
  logic [4:0]                 sum_s;
  logic [3:0]                 dig_s;
  logic                       cy_s;

`ifdef BCD_ADDSUB_CHECK_EN
  logic                       err_q, err_d;

  function automatic logic has_bad_digit(input logic [DIGITS-1:0][3:0] x,
                                         input logic [DIGITS-1:0][3:0] y);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (x[i] > 4'd9) | (y[i] > 4'd9);
    end
    return bad;
  endfunction
`endif

  // Per-digit decimal add with decimal-adjust; subtrahend is already nines-complemented.
  always_comb begin
    sum_s = {1'b0, a_q[idx_q]} + {1'b0, bop_q[idx_q]} + {4'b0000, c_q};
    if (sum_s > 5'd9) begin
      dig_s = sum_s[3:0] + 4'd6;
      cy_s  = 1'b1;
    end else begin
      dig_s = sum_s[3:0];
      cy_s  = 1'b0;
    end
  end

  // Next-state and datapath update for IDLE/RUN/DONE sequencing.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bop_d   = bop_q;
    wres_d  = wres_q;
    res_d   = res_q;
    idx_d   = idx_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
`ifdef BCD_ADDSUB_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d = a;
          // Subtract as A + (9..9 - B) + ~borrow, so the same digit adder serves both.
          for (int i = 0; i < DIGITS; i++) begin
            bop_d[i] = sub ? (4'd9 - b[4*i +: 4]) : b[4*i +: 4];
          end
          c_d     = sub ? ~cin : cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        wres_d[idx_q] = dig_s;
        c_d           = cy_s;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          res_d   = wres_d;
          cout_d  = cy_s;
`ifdef BCD_ADDSUB_CHECK_EN
          // A nines-complemented digit exceeds 9 exactly when the original did.
          err_d   = has_bad_digit(a_q, bop_q);
`endif
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      bop_q   <= '0;
      wres_q  <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef BCD_ADDSUB_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bop_q   <= bop_d;
      wres_q  <= wres_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
`ifdef BCD_ADDSUB_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;
  assign cout = cout_q;
`ifdef BCD_ADDSUB_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial (DIGITS=4): directed cases plus random valid-BCD
// operations against an integer-arithmetic decimal reference model.
module tb_bcd_addsub_serial;

  localparam int DIGITS = 4;
`ifdef BCD_ADDSUB_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        cin = 1'b0;
  logic        busy, done, cout, err;
  logic [15:0] res;

  int total = 0;
  int bad = 0;

  bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .res(res), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x);
    logic [15:0] r;
    int t;
    t = x;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference: plain integer add/subtract modulo 10^4.
  task automatic model(input bit sb, input logic [15:0] aa, input logic [15:0] bb, input bit ci,
                       output logic [15:0] r, output bit co);
    int t;
    if (!sb) begin
      t  = bcd2int(aa) + bcd2int(bb) + int'(ci);
      co = (t >= 10000);
      r  = int2bcd(t % 10000);
    end else begin
      t  = bcd2int(aa) - bcd2int(bb) - int'(ci);
      co = (t >= 0);
      r  = int2bcd(co ? t : t + 10000);
    end
  endtask

  task automatic run_op(input string tag, input bit sb, input logic [15:0] aa, input logic [15:0] bb,
                        input bit ci, input bit glitch, input logic [15:0] er, input bit ec, input bit ee);
    int n;
    int bc;
    @(negedge clk);
    start = 1'b1; sub = sb; a = aa; b = bb; cin = ci;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = ~sb; cin = ~ci;
    n  = 0;
    bc = busy ? 1 : 0;
    while (!done && n < 20) begin
      if (glitch && n == 1) begin
        start = 1'b1; a = 16'h1111; b = 16'h2222;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (busy) bc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd4);
    chk({tag, "_res"}, {16'h0000, res}, {16'h0000, er});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_res_hold"}, {16'h0000, res}, {16'h0000, er});
  endtask

  initial begin
    logic [15:0] ra, rb, er;
    bit          rs, rc, ec;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", {16'h0000, res}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    run_op("add_basic", 1'b0, 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("add_wrap", 1'b0, 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_cin", 1'b0, 16'h0999, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("sub_basic", 1'b1, 16'h5000, 16'h1234, 1'b0, 1'b0, 16'h3766, 1'b1, 1'b0);
    run_op("sub_borrow", 1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0, 16'h9900, 1'b0, 1'b0);
    run_op("start_ignored", 1'b0, 16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0);
    run_op("back_to_back", 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    // Abort an operation with reset while digit 2 is in flight.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 16'h4321; b = 16'h1111; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_res", {16'h0000, res}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 1'b0, 16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);

    // Invalid nibble: A+0 -> 10 is adjusted to 0 with carry, giving 0x1305.
    run_op("invalid", 1'b0, 16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h1305, 1'b0, ERR_ON);
    run_op("err_clear", 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      for (int d = 0; d < 4; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(9));
        rb[4*d +: 4] = 4'($urandom_range(9));
      end
      rs = 1'($urandom);
      rc = 1'($urandom);
      model(rs, ra, rb, rc, er, ec);
      run_op($sformatf("rand%0d", k), rs, ra, rb, rc, 1'b0, er, ec, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
